// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and the transmitter FSM encoding.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 14;
  localparam int unsigned FRAME_BITS       = 11;
  localparam int unsigned DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Parity bit that makes data+parity even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; writes when full and reads when empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: bytes queue in a small FIFO and are sent as
// start, d7..d0, even parity, stop frames, back-to-back while data remains.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk_3125,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t             state;
  tx_state_t             state_next;
  logic [CW-1:0]         cyc_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par;
  logic                  pop;
  logic                  last_cyc;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_head;

  assign tx_ready = (fifo_count < CNTW'(FIFO_DEPTH));
  assign tx_busy  = (state != ST_IDLE);
  assign last_cyc = (cyc_cnt == CW'(CLKS_PER_BIT - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk_3125),
    .rst_n   (rst_n),
    .wr_en   (tx_valid && tx_ready),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_done    = 1'b0;
    tx         = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (last_cyc) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg[DATA_BITS-1];
        if (last_cyc && bit_cnt == 3'd7) state_next = ST_PARITY;
      end
      ST_PARITY: begin
        tx = par;
        if (last_cyc) state_next = ST_STOP;
      end
      ST_STOP: begin
        // Pop on the final stop cycle so the next start bit follows with no idle gap.
        if (last_cyc) begin
          tx_done = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        shreg   <= fifo_head;
        par     <= even_parity(fifo_head);
        cyc_cnt <= '0;
        bit_cnt <= '0;
      end else if (state != ST_IDLE) begin
        if (last_cyc) begin
          cyc_cnt <= '0;
          if (state == ST_DATA) begin
            shreg   <= {shreg[DATA_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          cyc_cnt <= cyc_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed self-checking bench for uart_tx_buf: frame shape/timing, parity, buffering, same-edge push/pop, reset abort.
module tb_uart_tx_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_tx_buf #(
    .CLKS_PER_BIT (14),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_3125   (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  // Records tx/tx_done/tx_busy at each of the next n falling edges.
  task automatic capture(input int n, output logic [0:769] s, output logic [0:769] d,
                         output logic [0:769] b);
    s = '1; d = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s[i] = tx;
      d[i] = tx_done;
      b[i] = tx_busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else passed++;
    checks++; if (tx_done !== 1'b0) $display("FAIL reset_done got %b want 0", tx_done); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx_ready); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) $display("FAIL post_reset_idle got tx=%b busy=%b want 1/0", tx, tx_busy); else passed++;
  endtask

  task automatic test_single_0x41();
    logic [0:769] s, d, b;
    logic [10:0]  f = 11'b0_01000001_0_1;
    int err_tx = 0, err_done = 0, err_busy = 0;
    @(negedge clk); tx_data = 8'h41; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) $display("FAIL single_count got %0d want 1", fifo_count); else passed++;
    checks++; if (tx !== 1'b1) $display("FAIL single_latency tx got %b want 1 before next edge", tx); else passed++;
    capture(154, s, d, b);
    for (int i = 0; i < 154; i++) begin
      if (s[i] !== f[10 - i/14]) err_tx++;
      if (d[i] !== (i == 153)) err_done++;
      if (b[i] !== 1'b1) err_busy++;
    end
    checks++; if (err_tx != 0) $display("FAIL single_frame_bits got %0d bad cycles want 0", err_tx); else passed++;
    checks++; if (err_done != 0) $display("FAIL single_done got %0d bad cycles want 0", err_done); else passed++;
    checks++; if (err_busy != 0) $display("FAIL single_busy got %0d bad cycles want 0", err_busy); else passed++;
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0)
      $display("FAIL single_end_idle got busy=%b tx=%b done=%b want 0/1/0", tx_busy, tx, tx_done); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL single_end_count got %0d want 0", fifo_count); else passed++;
  endtask

  task automatic test_parity_0x07();
    logic [0:769] s, d, b;
    logic [10:0]  f = 11'b0_00000111_1_1;
    logic [7:0]   msg;
    logic         rx_par;
    int err_tx = 0, ndone = 0;
    @(negedge clk); tx_data = 8'h07; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); tx_valid = 1'b0;
    capture(154, s, d, b);
    for (int i = 0; i < 154; i++) begin
      if (s[i] !== f[10 - i/14]) err_tx++;
      if (d[i] === 1'b1) ndone++;
    end
    for (int k = 0; k < 8; k++) msg[7-k] = s[14*(k+1) + 7];
    rx_par = s[14*9 + 7];
    checks++; if (err_tx != 0) $display("FAIL parity_frame_bits got %0d bad cycles want 0", err_tx); else passed++;
    checks++; if (msg !== 8'h07) $display("FAIL parity_rx_msg got %h want 07", msg); else passed++;
    checks++; if (rx_par !== 1'b1) $display("FAIL parity_bit got %b want 1", rx_par); else passed++;
    checks++; if (ndone != 1) $display("FAIL parity_done_count got %0d want 1", ndone); else passed++;
    checks++; if (s[14*10 + 7] !== 1'b1) $display("FAIL parity_stop got %b want 1", s[14*10 + 7]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [0:769] s, d, b;
    logic [7:0]   bytes  [5] = '{8'h41, 8'h07, 8'hA5, 8'h3C, 8'h80};
    logic [10:0]  frames [5] = '{11'b0_01000001_0_1, 11'b0_00000111_1_1, 11'b0_10100101_0_1,
                                 11'b0_00111100_0_1, 11'b0_10000000_1_1};
    int err_tx = 0, err_done = 0, err_busy = 0;
    @(negedge clk); tx_data = bytes[0]; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1 || tx !== 1'b1)
      $display("FAIL b2b_first_push got count=%0d tx=%b want 1/1", fifo_count, tx); else passed++;
    fork
      capture(770, s, d, b);
      begin
        for (int k = 1; k < 5; k++) begin
          tx_data = bytes[k];
          @(posedge clk);
          @(negedge clk);
          if (k == 1) begin
            checks++; if (fifo_count !== 3'd1) $display("FAIL b2b_pop_push_count got %0d want 1", fifo_count); else passed++;
          end
        end
        checks++; if (fifo_count !== 3'd4) $display("FAIL b2b_full_count got %0d want 4", fifo_count); else passed++;
        checks++; if (tx_ready !== 1'b0) $display("FAIL b2b_full_ready got %b want 0", tx_ready); else passed++;
        tx_data = 8'h55;
        @(posedge clk);
        @(negedge clk); tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) $display("FAIL b2b_drop_count got %0d want 4", fifo_count); else passed++;
      end
    join
    for (int i = 0; i < 770; i++) begin
      if (s[i] !== frames[i/154][10 - (i%154)/14]) err_tx++;
      if (d[i] !== ((i % 154) == 153)) err_done++;
      if (b[i] !== 1'b1) err_busy++;
    end
    checks++; if (err_tx != 0) $display("FAIL b2b_frame_bits got %0d bad cycles want 0", err_tx); else passed++;
    checks++; if (err_done != 0) $display("FAIL b2b_done got %0d bad cycles want 0", err_done); else passed++;
    checks++; if (err_busy != 0) $display("FAIL b2b_busy_gap got %0d bad cycles want 0", err_busy); else passed++;
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL b2b_end got busy=%b count=%0d want 0/0", tx_busy, fifo_count); else passed++;
  endtask

  task automatic test_push_pop_same_edge();
    logic [0:769] s, d, b;
    logic [10:0]  frames [4] = '{11'b0_10100101_0_1, 11'b0_00111100_0_1,
                                 11'b0_10000000_1_1, 11'b0_01000001_0_1};
    int err_tx = 0;
    @(negedge clk); tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fork
      capture(616, s, d, b);
      begin
        tx_data = 8'h3C;
        @(posedge clk);
        @(negedge clk); tx_data = 8'h80;
        @(posedge clk);
        @(negedge clk); tx_valid = 1'b0;
        repeat (152) @(negedge clk);
        checks++; if (fifo_count !== 3'd2 || tx_done !== 1'b1)
          $display("FAIL same_edge_pre got count=%0d done=%b want 2/1", fifo_count, tx_done); else passed++;
        tx_data = 8'h41; tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) $display("FAIL same_edge_count got %0d want 2", fifo_count); else passed++;
      end
    join
    for (int i = 0; i < 616; i++)
      if (s[i] !== frames[i/154][10 - (i%154)/14]) err_tx++;
    checks++; if (err_tx != 0) $display("FAIL same_edge_order got %0d bad cycles want 0", err_tx); else passed++;
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL same_edge_end got busy=%b count=%0d want 0/0", tx_busy, fifo_count); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int err_tx = 0, ndone = 0, err_busy = 0, err_cnt = 0;
    @(negedge clk); tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); tx_data = 8'h10 + 8'(k);
      @(posedge clk);
    end
    @(negedge clk); tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) $display("FAIL abort_queued got %0d want 3", fifo_count); else passed++;
    repeat (57) @(negedge clk);
    checks++; if (tx !== 1'b0) $display("FAIL abort_pre_tx got %b want 0", tx); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL abort_tx got %b want 1", tx); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL abort_count got %0d want 0", fifo_count); else passed++;
    checks++; if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1)
      $display("FAIL abort_flags got busy=%b done=%b ready=%b want 0/0/1", tx_busy, tx_done, tx_ready); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) err_tx++;
      if (tx_done !== 1'b0) ndone++;
      if (tx_busy !== 1'b0) err_busy++;
      if (fifo_count !== 3'd0) err_cnt++;
    end
    checks++; if (err_tx != 0) $display("FAIL abort_idle_tx got %0d bad cycles want 0", err_tx); else passed++;
    checks++; if (ndone != 0) $display("FAIL abort_no_done got %0d pulses want 0", ndone); else passed++;
    checks++; if (err_busy != 0 || err_cnt != 0)
      $display("FAIL abort_idle_state got busy_bad=%0d count_bad=%0d want 0/0", err_busy, err_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_0x41();
    test_parity_0x07();
    test_back_to_back();
    test_push_pop_same_edge();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 14, clk_3125 cycles per serial bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries buffered ahead of the serialiser; power of two.
REQ-003 SHALL have port clk_3125  input  1  single 3.125 MHz clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  producer offers tx_data this cycle.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line; idle high; feeds the uart_rx1 rx input.
REQ-009 SHALL have port tx_busy  output  1  a frame is on the line.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse marking frame completion.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently buffered.

Function
REQ-012 SHALL accept a byte on a rising edge where tx_valid && tx_ready, and ignore tx_data otherwise.
REQ-013 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH), combinationally from the count register.
REQ-014 SHALL frame each byte as 11 bits: start 0, data bits d7 first through d0 last, parity, stop 1.
REQ-015 SHALL set parity bit = XOR of the 8 data bits (even parity over data+parity).
REQ-016 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles; one frame = 11*CLKS_PER_BIT = 154 cycles.
REQ-017 SHALL implement FSM IDLE -> START -> DATA (8 bits) -> PARITY -> STOP -> IDLE or START.
REQ-018 SHALL, in IDLE with FIFO non-empty at edge N, pop the head entry and drive tx=0 from edge N onward (START).
REQ-019 SHALL yield latency: byte written into an empty FIFO with FSM idle at edge N -> tx falls at edge N+1.
REQ-020 SHALL, at end of STOP with FIFO non-empty, go directly to START with no idle gap (back-to-back frames every 154 cycles).
REQ-021 SHALL assert tx_done for exactly the last clk_3125 cycle of STOP, once per frame.
REQ-022 SHALL assert tx_busy in START, DATA, PARITY and STOP; deassert in IDLE.
REQ-023 SHALL, on simultaneous push and pop in one edge, leave fifo_count unchanged and keep data order.
REQ-024 SHALL, with FIFO full, hold tx_ready low; a push attempt is dropped with no state change.
REQ-025 SHALL latch the popped byte into a shift register so FIFO writes never corrupt a frame in progress.
REQ-026 SHALL wrap the read and write pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, while rst_n is low, force tx=1, tx_busy=0, tx_done=0, fifo_count=0, tx_ready=1, FSM=IDLE, bit/cycle counters=0.
REQ-028 SHALL abort a frame in progress immediately on rst_n low (tx high asynchronously) and discard all buffered bytes.
REQ-029 SHALL start its first frame no earlier than the edge after the first push following rst_n release.

Structure
REQ-030 SHALL take CLKS_PER_BIT default, FRAME_BITS=11 and the FSM state enum from shared package uart_pkg.
REQ-031 SHALL instantiate one sub-module uart_tx_fifo (synchronous FIFO, depth FIFO_DEPTH, width 8, async active-low reset).

Verification
REQ-032 SHALL cover: push 0x41 once -> tx = 0,0,1,0,0,0,0,0,1,0,1 (start, d7..d0, parity 0, stop), 14 cycles each, one tx_done at cycle 154.
REQ-033 SHALL cover: push 0x07 -> parity bit 1; loopback into uart_rx1 -> rx_msg=0x07, rx_parity=1, rx_complete once.
REQ-034 SHALL cover: push 5 bytes back-to-back with the FSM idle -> first pops immediately, 4 buffered, tx_ready low, fifo_count=4; fifth accepted only after the first pop; five contiguous frames spanning 770 cycles.
REQ-035 SHALL cover: push at the same edge the FSM pops with fifo_count=2 -> fifo_count stays 2 and bytes leave in order.
REQ-036 SHALL cover: rst_n low at cycle 60 of a frame with 3 bytes queued -> tx=1 immediately, fifo_count=0, no tx_done, line idle after release.
